// File: rtl/alu_issue_ctrl_if.sv
// Bus bundle between the issue/writeback controller and its neighbours:
// the instruction source, the combinational vector ALU and the writeback sink.
// Big-endian bit numbering throughout ([0] is MSB).
interface alu_issue_ctrl_if;
  // instruction source
  logic        in_valid;
  logic        in_ready;
  logic [0:31] instr;
  logic [0:63] rA_data;
  logic [0:63] rB_data;
  // ALU drive / result
  logic [0:63] alu_rA;
  logic [0:63] alu_rB;
  logic [0:5]  alu_R_ins;
  logic [0:5]  alu_Op_code;
  logic [0:1]  alu_WW;
  logic [0:63] alu_result;
  // writeback
  logic        wb_valid;
  logic        wb_ready;
  logic [0:4]  wb_rd;
  logic [0:63] wb_data;
  logic        wb_err;

  // controller side
  modport master (
    input  in_valid, instr, rA_data, rB_data, alu_result, wb_ready,
    output in_ready, alu_rA, alu_rB, alu_R_ins, alu_Op_code, alu_WW,
           wb_valid, wb_rd, wb_data, wb_err
  );

  // environment side: source, ALU and writeback sink
  modport slave (
    output in_valid, instr, rA_data, rB_data, alu_result, wb_ready,
    input  in_ready, alu_rA, alu_rB, alu_R_ins, alu_Op_code, alu_WW,
           wb_valid, wb_rd, wb_data, wb_err
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue and writeback controller for the vector ALU. Registers a decoded
// R-type instruction and its operands onto the ALU inputs, holds them for a
// multicycle window on slow ops, captures the ALU result and presents it on
// a valid/ready writeback handshake. One transaction in flight at a time.
module alu_issue_ctrl #(
  parameter int unsigned SLOW_CYCLES = 4,
  parameter logic [0:5]  ALU_OPCODE  = 6'b101010
) (
  input  logic           clk,
  input  logic           reset,
  alu_issue_ctrl_if.master bus
);

  localparam logic [3:0] HOLD_INIT = 4'(SLOW_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD, DONE} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       ill_q;

  logic [0:5] dec_op;
  logic [0:5] dec_rins;
  logic       dec_legal;
  logic       exec_slow;

  // Register-address fields and the spare bits are not used by this block.
  logic unused_fields;
  assign unused_fields = ^bus.instr[11:23];

  // Decode of the instruction on the input port and of the issued op.
  always_comb begin
    dec_op    = bus.instr[0:5];
    dec_rins  = bus.instr[26:31];
    dec_legal = (dec_op == ALU_OPCODE) && (dec_rins >= 6'd1) && (dec_rins <= 6'd18);
    exec_slow = (bus.alu_R_ins == 6'b001110) || (bus.alu_R_ins == 6'b001111) ||
                (bus.alu_R_ins == 6'b010010);
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      ill_q           <= 1'b0;
      bus.in_ready    <= 1'b0;
      bus.alu_rA      <= '0;
      bus.alu_rB      <= '0;
      bus.alu_R_ins   <= '0;
      bus.alu_Op_code <= '0;
      bus.alu_WW      <= '0;
      bus.wb_valid    <= 1'b0;
      bus.wb_rd       <= '0;
      bus.wb_data     <= '0;
      bus.wb_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            bus.in_ready <= 1'b0;
            bus.wb_rd    <= bus.instr[6:10];
            ill_q        <= !dec_legal;
            // Illegal ops leave the ALU inputs on the previous instruction.
            if (dec_legal) begin
              bus.alu_rA      <= bus.rA_data;
              bus.alu_rB      <= bus.rB_data;
              bus.alu_R_ins   <= dec_rins;
              bus.alu_Op_code <= dec_op;
              bus.alu_WW      <= bus.instr[24:25];
            end
            // Illegal ops also pass through EXEC (without using the ALU) so
            // their response arrives with the same one-cycle latency.
            state <= EXEC;
          end else begin
            bus.in_ready <= 1'b1;
          end
        end
        EXEC: begin
          if (ill_q) begin
            bus.wb_data  <= '0;
            bus.wb_err   <= 1'b1;
            bus.wb_valid <= 1'b1;
            state        <= DONE;
          end else if (exec_slow && (HOLD_INIT != 4'd0)) begin
            cnt   <= HOLD_INIT;
            state <= HOLD;
          end else begin
            bus.wb_data  <= bus.alu_result;
            bus.wb_valid <= 1'b1;
            state        <= DONE;
          end
        end
        HOLD: begin
          // Counter stepping 1 -> 0 marks the capture edge.
          if (cnt <= 4'd1) begin
            cnt          <= '0;
            bus.wb_data  <= bus.alu_result;
            bus.wb_valid <= 1'b1;
            state        <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (bus.wb_valid && bus.wb_ready) begin
            bus.wb_valid <= 1'b0;
            bus.wb_err   <= 1'b0;
            bus.in_ready <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed vector table, hand-written corner
// sequences (writeback backpressure, reset mid-hold, SLOW_CYCLES=1) and a
// randomized phase checked against a transaction-level model.
module tb_alu_issue_ctrl;

  localparam logic [5:0] OPC   = 6'b101010;
  localparam logic [5:0] VAND  = 6'b000001;
  localparam logic [5:0] VOR   = 6'b000010;
  localparam logic [5:0] VADD  = 6'b000100;
  localparam logic [5:0] VDIV  = 6'b001110;
  localparam logic [5:0] VMOD  = 6'b001111;
  localparam logic [5:0] VSQRT = 6'b010010;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_issue_ctrl_if bus();
  alu_issue_ctrl_if bus1();

  alu_issue_ctrl #(.SLOW_CYCLES(4)) dut  (.clk(clk), .reset(reset), .bus(bus));
  alu_issue_ctrl #(.SLOW_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  // Stand-in for the vector ALU: a few recognisable ops, lane-wise add.
  function automatic logic [63:0] alu_fn(logic [5:0] r, logic [63:0] a, logic [63:0] b,
                                         logic [1:0] ww);
    logic [63:0] res, m;
    int w;
    res = '0;
    case (r)
      VAND:  res = a & b;
      VOR:   res = a | b;
      VADD: begin
        w = 8 << ww;
        m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        for (int l = 0; l < 64 / w; l++)
          res |= ((((a >> (l * w)) & m) + ((b >> (l * w)) & m)) & m) << (l * w);
      end
      VDIV:  res = (b == 0) ? '0 : a / b;
      VMOD:  res = (b == 0) ? '0 : a % b;
      VSQRT: res = a >> 1;
      default: res = a ^ b ^ {58'd0, r};
    endcase
    return res;
  endfunction

  always_comb bus.alu_result  = alu_fn(bus.alu_R_ins, bus.alu_rA, bus.alu_rB, bus.alu_WW);
  always_comb bus1.alu_result = alu_fn(bus1.alu_R_ins, bus1.alu_rA, bus1.alu_rB, bus1.alu_WW);

  int checks = 0;
  int failures = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model of what the ALU inputs should show: last legal instruction issued.
  logic [63:0] m_rA, m_rB;
  logic [5:0]  m_rins, m_op;
  logic [1:0]  m_ww;

  function automatic logic is_legal(logic [5:0] op, logic [5:0] ri);
    return (op == OPC) && (ri >= 6'd1) && (ri <= 6'd18);
  endfunction

  function automatic int exp_latency(logic [5:0] op, logic [5:0] ri);
    if (is_legal(op, ri) && (ri == VDIV || ri == VMOD || ri == VSQRT)) return 4;
    return 1;
  endfunction

  task automatic chk_alu(string nm);
    chk({nm, " alu_rA"}, bus.alu_rA, m_rA);
    chk({nm, " alu_rB"}, bus.alu_rB, m_rB);
    chk({nm, " alu_ctl"}, {bus.alu_Op_code, bus.alu_R_ins, bus.alu_WW}, {m_op, m_rins, m_ww});
  endtask

  // Present an instruction and return at the negedge after it is accepted.
  task automatic issue(logic [5:0] op, logic [4:0] rd, logic [1:0] ww, logic [5:0] ri,
                       logic [63:0] a, logic [63:0] b);
    int n = 0;
    while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
    if (!bus.in_ready) chk("issue in_ready timeout", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.instr    = {op, rd, 5'd1, 5'd2, 3'b000, ww, ri};
    bus.rA_data  = a;
    bus.rB_data  = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.instr    = $urandom;
    bus.rA_data  = {$urandom, $urandom};
    bus.rB_data  = {$urandom, $urandom};
    chk("in_ready low after accept", 64'(bus.in_ready), 64'd0);
    if (is_legal(op, ri)) begin
      m_rA = a; m_rB = b; m_op = op; m_rins = ri; m_ww = ww;
    end
  endtask

  // Measure accept-to-wb_valid latency and check the writeback payload.
  task automatic wait_wb(string nm, int exp_lat, logic [63:0] exp_data, logic exp_err,
                         logic [4:0] exp_rd);
    int lat = 0;
    while (!bus.wb_valid && lat < 64) begin
      chk({nm, " alu stable"}, bus.alu_rA ^ bus.alu_rB, m_rA ^ m_rB);
      chk({nm, " in_ready busy"}, 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, " wb_data"}, bus.wb_data, exp_data);
    chk({nm, " wb_rd/err"}, {bus.wb_rd, bus.wb_err}, {exp_rd, exp_err});
    chk_alu(nm);
  endtask

  // Hold off wb_ready for 'hold' cycles, then complete the handshake.
  task automatic retire(string nm, int hold, logic [63:0] exp_data, logic exp_err,
                        logic [4:0] exp_rd);
    for (int i = 0; i < hold; i++) begin
      bus.wb_ready = 1'b0;
      @(negedge clk);
      chk({nm, " held valid/ready"}, {bus.wb_valid, bus.in_ready}, 2'b10);
      chk({nm, " held data"}, bus.wb_data, exp_data);
      chk({nm, " held rd/err"}, {bus.wb_rd, bus.wb_err}, {exp_rd, exp_err});
      chk({nm, " held alu_rA"}, bus.alu_rA, m_rA);
    end
    bus.wb_ready = 1'b1;
    @(negedge clk);
    bus.wb_ready = 1'b0;
    chk({nm, " post-wb valid/err/ready"}, {bus.wb_valid, bus.wb_err, bus.in_ready}, 3'b001);
  endtask

  typedef struct {
    string       nm;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [1:0]  ww;
    logic [5:0]  ri;
    logic [63:0] a, b;
    int          lat;
    logic [63:0] data;
    logic        err;
    int          hold;
  } vec_t;

  vec_t tv[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  r_op, r_ri;
    logic [4:0]  r_rd;
    logic [1:0]  r_ww;
    logic [63:0] r_a, r_b, r_d;
    logic        r_legal;
    int          lat;

    tv[0] = '{"vand",   OPC,       5'd3,  2'b10, VAND,   64'd15, 64'd14, 1, 64'd14, 1'b0, 0};
    tv[1] = '{"vadd",   OPC,       5'd4,  2'b00, VADD,   64'hFFFFFFFF_FFFFFFFF,
              64'h00000000_11111111, 1, 64'hFFFFFFFF_10101010, 1'b0, 0};
    tv[2] = '{"vdiv",   OPC,       5'd5,  2'b11, VDIV,   64'd100, 64'd7, 4, 64'd14, 1'b0, 0};
    tv[3] = '{"bad op", 6'b000001, 5'd7,  2'b01, VAND,   64'd1, 64'd2, 1, 64'd0, 1'b1, 0};
    tv[4] = '{"bad ri", OPC,       5'd8,  2'b01, 6'b010011, 64'd3, 64'd4, 1, 64'd0, 1'b1, 1};
    tv[5] = '{"vsqrt",  OPC,       5'd10, 2'b11, VSQRT,  64'h100, 64'd0, 4, 64'h80, 1'b0, 0};
    tv[6] = '{"vor",    OPC,       5'd11, 2'b10, VOR,    64'd15, 64'd14, 1, 64'd15, 1'b0, 2};
    tv[7] = '{"vmod",   OPC,       5'd12, 2'b11, VMOD,   64'd100, 64'd7, 4, 64'd2, 1'b0, 0};

    bus.in_valid = 0; bus.instr = '0; bus.rA_data = '0; bus.rB_data = '0; bus.wb_ready = 0;
    bus1.in_valid = 0; bus1.instr = '0; bus1.rA_data = '0; bus1.rB_data = '0; bus1.wb_ready = 0;
    m_rA = '0; m_rB = '0; m_op = '0; m_rins = '0; m_ww = '0;

    // Reset state and first-edge in_ready.
    @(negedge clk);
    chk("reset in_ready/wb_valid/err", {bus.in_ready, bus.wb_valid, bus.wb_err}, 3'b000);
    chk("reset wb_data", bus.wb_data, 64'd0);
    chk("reset wb_rd", 64'(bus.wb_rd), 64'd0);
    chk_alu("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("in_ready after first edge", 64'(bus.in_ready), 64'd1);

    // Directed vector table.
    foreach (tv[i]) begin
      issue(tv[i].op, tv[i].rd, tv[i].ww, tv[i].ri, tv[i].a, tv[i].b);
      wait_wb(tv[i].nm, tv[i].lat, tv[i].data, tv[i].err, tv[i].rd);
      retire(tv[i].nm, tv[i].hold, tv[i].data, tv[i].err, tv[i].rd);
    end

    // Backpressure with a pending instruction that must wait for the handshake.
    issue(OPC, 5'd13, 2'b10, VAND, 64'hF0F0, 64'hFF00);
    wait_wb("bp", 1, 64'hF000, 1'b0, 5'd13);
    bus.in_valid = 1'b1;
    bus.instr    = {OPC, 5'd14, 5'd1, 5'd2, 3'b000, 2'b11, VOR};
    bus.rA_data  = 64'h1;
    bus.rB_data  = 64'h6;
    retire("bp", 5, 64'hF000, 1'b0, 5'd13);
    chk("bp pending not yet taken", bus.alu_rA, 64'hF0F0);
    issue(OPC, 5'd14, 2'b11, VOR, 64'h1, 64'h6);
    wait_wb("bp next", 1, 64'h7, 1'b0, 5'd14);
    retire("bp next", 0, 64'h7, 1'b0, 5'd14);

    // Reset in the middle of a VMOD hold window.
    issue(OPC, 5'd9, 2'b11, VMOD, 64'd100, 64'd7);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst async valid/ready/err", {bus.wb_valid, bus.in_ready, bus.wb_err}, 3'b000);
    chk("rst async alu_rA", bus.alu_rA, 64'd0);
    chk("rst async alu_rB", bus.alu_rB, 64'd0);
    chk("rst async alu_ctl", {bus.alu_Op_code, bus.alu_R_ins, bus.alu_WW}, 14'd0);
    chk("rst async wb_rd/data", {bus.wb_rd, bus.wb_data}, 69'd0);
    m_rA = '0; m_rB = '0; m_op = '0; m_rins = '0; m_ww = '0;
    @(negedge clk);
    reset = 1'b0;
    lat = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.wb_valid) lat++;
    end
    chk("no wb after reset abort", 64'(lat), 64'd0);
    issue(OPC, 5'd6, 2'b10, VOR, 64'd15, 64'd14);
    wait_wb("vor after reset", 1, 64'd15, 1'b0, 5'd6);
    retire("vor after reset", 0, 64'd15, 1'b0, 5'd6);

    // SLOW_CYCLES=1 instance: slow op completes in one cycle.
    chk("s1 in_ready", 64'(bus1.in_ready), 64'd1);
    bus1.in_valid = 1'b1;
    bus1.instr    = {OPC, 5'd2, 5'd1, 5'd2, 3'b000, 2'b11, VDIV};
    bus1.rA_data  = 64'd100;
    bus1.rB_data  = 64'd7;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    lat = 0;
    while (!bus1.wb_valid && lat < 20) begin @(negedge clk); lat++; end
    chk("s1 vdiv latency", 64'(lat), 64'd1);
    chk("s1 vdiv data", bus1.wb_data, 64'd14);
    bus1.wb_ready = 1'b1;
    @(negedge clk);
    bus1.wb_ready = 1'b0;
    chk("s1 post-wb", {bus1.wb_valid, bus1.in_ready}, 2'b01);

    // Randomized transactions against the transaction-level model.
    for (int t = 0; t < 40; t++) begin
      r_op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 41)) : OPC;
      r_ri = 6'($urandom_range(0, 21));
      r_rd = 5'($urandom);
      r_ww = 2'($urandom);
      r_a  = {$urandom, $urandom};
      r_b  = ($urandom_range(0, 3) == 0) ? 64'd0 : {32'd0, $urandom};
      r_legal = is_legal(r_op, r_ri);
      r_d  = r_legal ? alu_fn(r_ri, r_a, r_b, r_ww) : 64'd0;
      issue(r_op, r_rd, r_ww, r_ri, r_a, r_b);
      wait_wb("rand", exp_latency(r_op, r_ri), r_d, !r_legal, r_rd);
      retire("rand", $urandom_range(0, 3), r_d, !r_legal, r_rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
